// File: rtl/reg_file_pkg.sv
// Shared sizing for the rename register file: architectural register count,
// index width, and the default ROB tag and data widths.
package reg_file_pkg;
  localparam int REG_COUNT    = 32;
  localparam int REG_IDX_W    = 5;
  localparam int ROB_ID_W_DEF = 4;
  localparam int DATA_W_DEF   = 32;
endpackage

// File: rtl/reg_read_port.sv
// One dispatcher read port: selects a register's value/busy/tag, forces x0 to
// zero, and forwards a same-cycle commit that retires the register's producer.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_ID_W = ROB_ID_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic [REG_IDX_W-1:0]                 rs,
  input  logic                                 rdy,
  input  logic                                 commit_en,
  input  logic [REG_IDX_W-1:0]                 commit_rd,
  input  logic [ROB_ID_W-1:0]                  commit_tag,
  input  logic [DATA_W-1:0]                    commit_val,
  input  logic [REG_COUNT-1:0][DATA_W-1:0]     value_arr,
  input  logic [REG_COUNT-1:0]                 busy_arr,
  input  logic [REG_COUNT-1:0][ROB_ID_W-1:0]   tag_arr,
  output logic [DATA_W-1:0]                    val,
  output logic                                 busy,
  output logic [ROB_ID_W-1:0]                  tag
);

  logic hit_s;

  // Commit bypass is only taken when the commit is really retiring this register's producer
  always_comb begin
    hit_s = 1'b0;
    if (rdy && commit_en && (commit_rd == rs) && busy_arr[rs] &&
        (tag_arr[rs] == commit_tag)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Output mux: x0 is hardwired zero, then bypass, then stored state
  always_comb begin
    val  = '0;
    busy = 1'b0;
    tag  = '0;
    if (rs == {REG_IDX_W{1'b0}}) begin
      val  = '0;
      busy = 1'b0;
      tag  = '0;
    end else if (hit_s) begin
      val  = commit_val;
      busy = 1'b0;
      tag  = tag_arr[rs];
    end else begin
      val  = value_arr[rs];
      busy = busy_arr[rs];
      tag  = tag_arr[rs];
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags for an out-of-order core:
// commit writes values, rename marks registers busy on a ROB tag, flush drops tags.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_ID_W = ROB_ID_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [DATA_W-1:0]    V1,
  output logic [DATA_W-1:0]    V2,
  output logic                 Q1_busy,
  output logic                 Q2_busy,
  output logic [ROB_ID_W-1:0]  Q1,
  output logic [ROB_ID_W-1:0]  Q2,
  input  logic                 rename_en,
  input  logic [4:0]           rename_rd,
  input  logic [ROB_ID_W-1:0]  rename_tag,
  input  logic                 commit_en,
  input  logic [4:0]           commit_rd,
  input  logic [ROB_ID_W-1:0]  commit_tag,
  input  logic [DATA_W-1:0]    commit_val
);

  logic [REG_COUNT-1:0][DATA_W-1:0]   value_r;
  logic [REG_COUNT-1:0]               busy_r;
  logic [REG_COUNT-1:0][ROB_ID_W-1:0] tag_r;
  logic                               commit_wr_s;
  logic                               rename_wr_s;

  // Writes to x0 are dropped so it stays zero and never busy
  always_comb begin
    commit_wr_s = 1'b0;
    rename_wr_s = 1'b0;
    if (commit_en && (commit_rd != 5'd0)) begin
      commit_wr_s = 1'b1;
    end else begin
      commit_wr_s = 1'b0;
    end
    if (rename_en && (rename_rd != 5'd0)) begin
      rename_wr_s = 1'b1;
    end else begin
      rename_wr_s = 1'b0;
    end
  end

  // State update; a later rename assignment overrides the commit's busy clear
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= '0;
      busy_r  <= '0;
      tag_r   <= '0;
    end else if (rdy) begin
      if (commit_wr_s) begin
        value_r[commit_rd] <= commit_val;
      end
      if (flush) begin
        busy_r <= '0;
        tag_r  <= '0;
      end else begin
        if (commit_wr_s && (tag_r[commit_rd] == commit_tag)) begin
          busy_r[commit_rd] <= 1'b0;
        end
        if (rename_wr_s) begin
          busy_r[rename_rd] <= 1'b1;
          tag_r[rename_rd]  <= rename_tag;
        end
      end
    end
  end

  reg_read_port #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_port1 (
    .rs         (rs1),
    .rdy        (rdy),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .value_arr  (value_r),
    .busy_arr   (busy_r),
    .tag_arr    (tag_r),
    .val        (V1),
    .busy       (Q1_busy),
    .tag        (Q1)
  );

  reg_read_port #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_port2 (
    .rs         (rs2),
    .rdy        (rdy),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .value_arr  (value_r),
    .busy_arr   (busy_r),
    .tag_arr    (tag_r),
    .val        (V2),
    .busy       (Q2_busy),
    .tag        (Q2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file against an array-based reference
// model, preceded by directed rename/commit/flush/x0 scenarios.
module tb_reg_file;
  localparam int RW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, rdy, flush;
  logic [4:0]    rs1, rs2;
  logic [DW-1:0] V1, V2;
  logic          Q1_busy, Q2_busy;
  logic [RW-1:0] Q1, Q2;
  logic          rename_en, commit_en;
  logic [4:0]    rename_rd, commit_rd;
  logic [RW-1:0] rename_tag, commit_tag;
  logic [DW-1:0] commit_val;

  always #5 clk = ~clk;

  reg_file #(.ROB_ID_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rs1(rs1), .rs2(rs2), .V1(V1), .V2(V2),
    .Q1_busy(Q1_busy), .Q2_busy(Q2_busy), .Q1(Q1), .Q2(Q2),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_val(commit_val)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_val  [32];
  bit            m_busy [32];
  logic [RW-1:0] m_tag  [32];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected read result for one source index under the current inputs
  task automatic model_read(input logic [4:0] rs, output logic [DW-1:0] ev,
                            output logic eb, output logic [RW-1:0] eq);
    if (rs == 5'd0) begin
      ev = '0; eb = 1'b0; eq = '0;
    end else begin
      ev = m_val[rs]; eb = m_busy[rs]; eq = m_tag[rs];
      if (rdy && commit_en && commit_rd == rs && m_busy[rs] && m_tag[rs] == commit_tag) begin
        ev = commit_val; eb = 1'b0;
      end
    end
  endtask

  task automatic read_check();
    logic [DW-1:0] ev;
    logic          eb;
    logic [RW-1:0] eq;
    if (!rst) begin
      model_read(rs1, ev, eb, eq);
      check("V1", V1, ev); check("Q1_busy", Q1_busy, eb); check("Q1", Q1, eq);
      model_read(rs2, ev, eb, eq);
      check("V2", V2, ev); check("Q2_busy", Q2_busy, eb); check("Q2", Q2, eq);
    end
  endtask

  // Apply one clock's effect to the model: commit first, then rename overrides
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      if (commit_en && commit_rd != 5'd0) begin
        m_val[commit_rd] = commit_val;
        if (!flush && m_tag[commit_rd] == commit_tag) m_busy[commit_rd] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
      end else if (rename_en && rename_rd != 5'd0) begin
        m_busy[rename_rd] = 1'b1;
        m_tag[rename_rd]  = rename_tag;
      end
    end
  endtask

  task automatic tick();
    #2;
    read_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    rename_en = 1'b0; rename_rd = 5'd0; rename_tag = '0;
    commit_en = 1'b0; commit_rd = 5'd0; commit_tag = '0; commit_val = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    idle();
    rs1 = 5'd0; rs2 = 5'd0;
    rst = 1'b1;
    rename_en = 1'b1; rename_rd = 5'd9; rename_tag = 4'd5;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #2;
      check("rst_V1", V1, 32'd0); check("rst_busy1", Q1_busy, 1'b0); check("rst_Q1", Q1, 4'd0);
      tick();
    end

    // Rename x5 tag 3 is visible to the dispatcher
    rename_en = 1'b1; rename_rd = 5'd5; rename_tag = 4'd3; tick();
    idle(); rs1 = 5'd5; #2;
    check("ren_busy", Q1_busy, 1'b1); check("ren_tag", Q1, 4'd3);
    tick();

    // Matching commit is forwarded in the same cycle and then held
    commit_en = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_val = 32'hDEAD; #2;
    check("byp_V1", V1, 32'hDEAD); check("byp_busy", Q1_busy, 1'b0);
    tick();
    idle(); #2;
    check("held_V1", V1, 32'hDEAD); check("held_busy", Q1_busy, 1'b0);
    tick();

    // Stale commit writes the value but keeps the newer rename
    rename_en = 1'b1; rename_rd = 5'd5; rename_tag = 4'd3; tick();
    rename_tag = 4'd7; tick();
    idle(); commit_en = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_val = 32'd1; tick();
    idle(); #2;
    check("stale_V", V1, 32'd1); check("stale_busy", Q1_busy, 1'b1); check("stale_Q", Q1, 4'd7);
    tick();

    // Same-cycle rename and commit on x6
    rename_en = 1'b1; rename_rd = 5'd6; rename_tag = 4'd2;
    commit_en = 1'b1; commit_rd = 5'd6; commit_tag = 4'd9; commit_val = 32'd4; tick();
    idle(); rs1 = 5'd6; #2;
    check("rc_V", V1, 32'd4); check("rc_busy", Q1_busy, 1'b1); check("rc_Q", Q1, 4'd2);
    tick();

    // Flush drops tags, keeps the same-cycle commit value, ignores the rename
    for (int i = 1; i <= 4; i++) begin
      rename_en = 1'b1; rename_rd = 5'(i); rename_tag = 4'(i); tick();
    end
    idle(); flush = 1'b1; commit_en = 1'b1; commit_rd = 5'd2; commit_tag = 4'd0; commit_val = 32'd8;
    rename_en = 1'b1; rename_rd = 5'd3; rename_tag = 4'd5; tick();
    idle();
    for (int i = 1; i <= 4; i++) begin
      rs1 = 5'(i); #2;
      check("fl_busy", Q1_busy, 1'b0);
      if (i == 2) check("fl_V2", V1, 32'd8);
      tick();
    end

    // x0 ignores commit and rename
    commit_en = 1'b1; commit_rd = 5'd0; commit_val = 32'h55;
    rename_en = 1'b1; rename_rd = 5'd0; rename_tag = 4'd1; tick();
    idle(); rs1 = 5'd0; #2;
    check("x0_V", V1, 32'd0); check("x0_busy", Q1_busy, 1'b0);
    tick();

    // Random traffic over a few registers so renames, commits and reads collide
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom % 300) == 0;
      rdy        = ($urandom % 8) != 0;
      flush      = ($urandom % 40) == 0;
      rename_en  = $urandom % 2;
      rename_rd  = 5'($urandom % 8);
      rename_tag = 4'($urandom);
      commit_en  = $urandom % 2;
      commit_rd  = 5'($urandom % 8);
      commit_tag = ($urandom % 2) ? m_tag[commit_rd] : 4'($urandom);
      commit_val = $urandom;
      rs1        = ($urandom % 2) ? commit_rd : 5'($urandom % 8);
      rs2        = 5'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter ROB_ID_W, default 4, SHALL set the ROB tag width (16 in-flight entries).
REQ-002 Parameter DATA_W, default 32, SHALL set the register value width.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global ready; when low, all state SHALL hold.
REQ-006 flush  in  1  ROB mispredict; clears all rename tags.
REQ-007 rs1, rs2  in  5 each  dispatcher source register indices.
REQ-008 V1, V2  out  DATA_W each  source values (combinational).
REQ-009 Q1_busy, Q2_busy  out  1 each  source awaits an in-flight producer.
REQ-010 Q1, Q2  out  ROB_ID_W each  producer ROB tag; valid only when busy.
REQ-011 rename_en  in  1  dispatcher claims rd for a new instruction.
REQ-012 rename_rd  in  5  destination register being renamed.
REQ-013 rename_tag  in  ROB_ID_W  ROB id allocated to it (ROB tail).
REQ-014 commit_en  in  1  ROB commit strobe.
REQ-015 commit_rd  in  5  committing destination register.
REQ-016 commit_tag  in  ROB_ID_W  committing ROB id (ROB head).
REQ-017 commit_val  in  DATA_W  committed result.

Function
REQ-018 Per register i: value[i] (DATA_W), busy[i] (1), tag[i] (ROB_ID_W).
REQ-019 Commit, rdy high, commit_en, commit_rd!=0: value[commit_rd] <= commit_val.
REQ-020 Same commit: busy cleared only if tag[commit_rd]==commit_tag; otherwise the newer rename is kept.
REQ-021 Rename, rdy high, rename_en, rename_rd!=0: busy <= 1, tag <= rename_tag.
REQ-022 Rename and commit to the same register in one cycle: rename wins for busy/tag; value still written.
REQ-023 flush: all busy <= 0 and all tags <= 0, values kept; a commit_en in the flush cycle SHALL still write its value; a rename_en in the flush cycle SHALL be ignored.
REQ-024 x0: value 0, never busy; rs==0 reads V=0, busy=0 regardless of writes.
REQ-025 Read bypass: if commit_en, commit_rd==rs!=0 and commit_tag==tag[rs] with busy[rs], output V=commit_val, busy=0 in the same cycle.
REQ-026 Reads SHALL NOT bypass a same-cycle rename; the dispatcher resolves self-dependence.
REQ-027 Otherwise V=value[rs], busy=busy[rs], Q=tag[rs]; zero-cycle read latency.
REQ-028 rdy low: no writes, reads stay combinational from current state.
REQ-029 Tags wrap modulo 2^ROB_ID_W; comparison is equality only.

Reset
REQ-030 rst SHALL clear all value, busy and tag state to 0 in one cycle, overriding flush, rename and commit.
REQ-031 After rst every read SHALL return V=0, busy=0, Q=0.
REQ-032 rst mid-operation SHALL discard pending renames; no partial state survives.

Structure
REQ-033 REG_COUNT=32, REG_IDX_W=5, ROB_ID_W and DATA_W defaults SHALL live in the shared define package.
REQ-034 Read logic for the two ports is identical; one sub-module reg_read_port (bypass + x0 mux), instantiated twice.
REQ-035 No memory macro; flop arrays, 32x(DATA_W+ROB_ID_W+1).

Verification
REQ-036 Rename x5 tag 3, then read rs1=5 -> Q1_busy=1, Q1=3.
REQ-037 x5 busy tag 3; commit rd=5 tag 3 val 0xDEAD with rs1=5 -> same cycle V1=0xDEAD, busy=0; next cycle value held.
REQ-038 Rename x5 tag 3, rename x5 tag 7, commit rd=5 tag 3 val 1 -> value[5]=1, busy=1, Q=7.
REQ-039 Same cycle rename x6 tag 2 and commit x6 tag 9 val 4 -> busy=1, Q=2, value[6]=4.
REQ-040 Rename x1..x4, assert flush with commit x2 val 8 -> all busy=0, value[2]=8.
REQ-041 Commit rd=0 val 0x55, rename rd=0 -> rs1=0 gives V1=0, Q1_busy=0.
